// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding, load-use and MC-scoreboard hazard unit for the 5-stage pipeline.
// EX operand selects, ID bypass from the MC result bus, and the front-end stall.
module fwd_hazard_scoreboard #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned MC_LAT  = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic [REG_W-1:0]           id_rd,
    input  logic                       id_reg_write,
    input  logic [NUM_SRC*REG_W-1:0]   ex_src,
    input  logic [REG_W-1:0]           ex_rd,
    input  logic                       ex_mem_read,
    input  logic                       ex_mc_issue,
    input  logic                       mem_reg_write,
    input  logic [REG_W-1:0]           mem_rd,
    input  logic                       wb_reg_write,
    input  logic [REG_W-1:0]           wb_rd,
    output logic [NUM_SRC*2-1:0]       forward_sel,
    output logic [NUM_SRC-1:0]         id_mc_bypass,
    output logic                       stall,
    output logic                       mc_retire_valid,
    output logic [REG_W-1:0]           mc_retire_rd,
    output logic [CNT_W-1:0]           stall_count
);

    localparam int unsigned SEL_W = 2;

    logic [MC_LAT-1:0] sb_valid;
    logic [REG_W-1:0]  sb_rd [MC_LAT];

    logic [NUM_SRC-1:0] src_pending;
    logic               rd_pending;
    logic               load_use;
    logic               rd_retiring;

    // Scoreboard shift register and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid    <= '0;
            stall_count <= '0;
            for (int unsigned k = 0; k < MC_LAT; k++) begin
                sb_rd[k] <= '0;
            end
        end else begin
            sb_valid[0] <= ex_mc_issue && (ex_rd != '0);
            sb_rd[0]    <= ex_rd;
            for (int unsigned k = 1; k < MC_LAT; k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    assign mc_retire_valid = sb_valid[MC_LAT-1];
    assign mc_retire_rd    = sb_rd[MC_LAT-1];

    // Operand forwarding, pending-set lookup and bypass selection
    always_comb begin
        forward_sel  = '0;
        id_mc_bypass = '0;
        src_pending  = '0;
        load_use     = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ex_src[i*REG_W +: REG_W] != '0) begin
                if (mem_reg_write && (mem_rd == ex_src[i*REG_W +: REG_W])) begin
                    forward_sel[i*SEL_W +: SEL_W] = 2'b10;
                end else if (wb_reg_write && (wb_rd == ex_src[i*REG_W +: REG_W])) begin
                    forward_sel[i*SEL_W +: SEL_W] = 2'b01;
                end
            end
            if (id_src[i*REG_W +: REG_W] != '0) begin
                src_pending[i] = ex_mc_issue && (ex_rd == id_src[i*REG_W +: REG_W]);
                for (int unsigned k = 0; k < MC_LAT-1; k++) begin
                    if (sb_valid[k] && (sb_rd[k] == id_src[i*REG_W +: REG_W])) begin
                        src_pending[i] = 1'b1;
                    end
                end
                // A younger in-flight write to the same register shadows the retiring one
                id_mc_bypass[i] = sb_valid[MC_LAT-1]
                                  && (sb_rd[MC_LAT-1] == id_src[i*REG_W +: REG_W])
                                  && !src_pending[i];
                if (ex_mem_read && (ex_rd == id_src[i*REG_W +: REG_W])) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // Destination lookup for write-after-write ordering against MC ops
    always_comb begin
        rd_pending  = 1'b0;
        rd_retiring = 1'b0;
        if (id_rd != '0) begin
            rd_pending  = ex_mc_issue && (ex_rd == id_rd);
            rd_retiring = sb_valid[MC_LAT-1] && (sb_rd[MC_LAT-1] == id_rd);
            for (int unsigned k = 0; k < MC_LAT-1; k++) begin
                if (sb_valid[k] && (sb_rd[k] == id_rd)) begin
                    rd_pending = 1'b1;
                end
            end
        end
    end

    assign stall = load_use || (|src_pending) || (id_reg_write && (rd_pending || rd_retiring));

endmodule
